uart_tx_arbiter: RTL and testbench

Shares one uart_transmitter between NUM_REQ byte-producing requesters using round-robin arbitration.
Latches the winning requester's byte, drives the transmitter's start/data inputs, and tracks the frame through the transmitter's active flag.
Returns per-requester grant and completion pulses.
Sits between on-chip sources (status reporter, command echo, debug dump) and the single UART TX pin.

---
 rtl/uart_arb_pkg.sv | 38 +++
 rtl/uart_tx_arbiter_picker.sv | 20 ++
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and the round-robin search used by uart_tx_arbiter.
package uart_arb_pkg;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned PICK_W  = $clog2(MAX_REQ);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_ACT,
    ST_WAIT_END,
    ST_GAP
  } arb_state_e;

  typedef struct packed {
    logic              valid;
    logic [PICK_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req[num-1:0] searching ptr+1, ptr+2, ... with wrap at num.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [PICK_W-1:0]  ptr,
                                       input int unsigned        num);
    rr_pick_t    res;
    int unsigned k;
    res = '0;
    for (int unsigned i = 1; i <= MAX_REQ; i++) begin
      k = 32'(ptr) + i;
      if (k >= num) k = k - num;
      if (i <= num && !res.valid && req[PICK_W'(k)]) begin
        res.valid = 1'b1;
        res.idx   = PICK_W'(k);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_picker.sv
// Combinational round-robin search over NUM_REQ requesters.
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned OWNER_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [OWNER_W-1:0] ptr_i,
  output logic               valid_o,
  output logic [OWNER_W-1:0] idx_o
);

  rr_pick_t pick;

  assign pick    = rr_pick(MAX_REQ'(req_i), PICK_W'(ptr_i), NUM_REQ);
  assign valid_o = pick.valid;
  assign idx_o   = OWNER_W'(pick.idx);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between NUM_REQ byte sources.
// Optional launch watchdog: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ        = 4,
  parameter  int unsigned DATA_W         = 8,
  parameter  int unsigned GAP_CYCLES     = 16,
  parameter  int unsigned TIMEOUT_CYCLES = 1_000_000,
  localparam int unsigned OWNER_W        = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] data_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic                      tx_start_o,
  output logic [DATA_W-1:0]         tx_data_o,
  input  logic                      tx_active_i,
  output logic                      busy_o,
  output logic [OWNER_W-1:0]        owner_o,
  output logic                      err_o
);

  localparam int unsigned        GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam bit                 GAP_SKIP = (GAP_CYCLES == 0);
  localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam logic [OWNER_W-1:0] RR_INIT  = OWNER_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT_CYCLES < 1 ||
      TIMEOUT_CYCLES > (1 << 20)) begin : g_param_check
    $error("uart_tx_arbiter: parameter out of range");
  end

  arb_state_e           state_q, state_d;
  logic [OWNER_W-1:0]   rr_ptr_q;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [NUM_REQ-1:0]   gnt_d, done_d;
  logic                 grant_en;
  logic                 pick_valid;
  logic [OWNER_W-1:0]   pick_idx;
  logic                 wd_expired;
  logic [DATA_W-1:0]    data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = data_i[g*DATA_W +: DATA_W];
  end

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i   (req_i),
    .ptr_i   (rr_ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [19:0] WD_LAST = 20'(TIMEOUT_CYCLES - 1);
  logic [19:0] wd_q;

  assign wd_expired = (wd_q == WD_LAST);

  always_ff @(posedge clk_i) begin
    if (reset_i || state_q != ST_LAUNCH) wd_q <= '0;
    else                                 wd_q <= wd_q + 20'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) err_o <= 1'b0;
    else         err_o <= (state_q == ST_LAUNCH) && !tx_active_i && wd_expired;
  end
`else
  assign wd_expired = 1'b0;
  assign err_o      = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    gnt_d    = '0;
    done_d   = '0;
    grant_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_en        = 1'b1;
          gnt_d[pick_idx] = 1'b1;
          state_d         = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        // An active flag wins over a watchdog expiry in the same cycle.
        if (tx_active_i) begin
          state_d = ST_WAIT_ACT;
        end else if (wd_expired) begin
          state_d = GAP_SKIP ? ST_IDLE : ST_GAP;
          gap_d   = GAP_LOAD;
        end
      end
      ST_WAIT_ACT: state_d = ST_WAIT_END;
      ST_WAIT_END: begin
        if (!tx_active_i) begin
          done_d[owner_o] = 1'b1;
          state_d         = GAP_SKIP ? ST_IDLE : ST_GAP;
          gap_d           = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr_q  <= RR_INIT;
      owner_o   <= '0;
      tx_data_o <= '0;
      gnt_o     <= '0;
      done_o    <= '0;
      gap_q     <= '0;
    end else begin
      gnt_o  <= gnt_d;
      done_o <= done_d;
      gap_q  <= gap_d;
      if (grant_en) begin
        rr_ptr_q  <= pick_idx;
        owner_o   <= pick_idx;
        tx_data_o <= data_arr[pick_idx];
      end
    end
  end

  assign tx_start_o = (state_q == ST_LAUNCH);
  assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter with a transaction-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned DW  = 8;
  localparam int unsigned GAP = 6;
  localparam int unsigned TMO = 100;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*DW-1:0] data;
  logic [N-1:0]    gnt, done;
  logic            tx_start, tx_active, busy, err;
  logic [DW-1:0]   tx_data;
  logic [1:0]      owner;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ        (N),
    .DATA_W         (DW),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_i       (req),
    .data_i      (data),
    .gnt_o       (gnt),
    .done_o      (done),
    .tx_start_o  (tx_start),
    .tx_data_o   (tx_data),
    .tx_active_i (tx_active),
    .busy_o      (busy),
    .owner_o     (owner),
    .err_o       (err)
  );

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  int unsigned   last_owner;
  logic [DW-1:0] exp_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Next requester in circular order after the last winner.
  function automatic int unsigned rr_next(input logic [N-1:0] mask, input int unsigned last);
    for (int unsigned i = 1; i <= N; i++)
      if (mask[(last + i) % N]) return (last + i) % N;
    return N;
  endfunction

  task automatic expect_grant(input int unsigned exp_lat);
    int unsigned k      = rr_next(req, last_owner);
    int unsigned n      = 0;
    bit          stable = 1'b1;
    do begin
      tick();
      n++;
      if (gnt == '0 && tx_data !== exp_data) stable = 1'b0;
    end while (gnt == '0 && n < 200);
    check_eq("data_hold", 32'(stable), 32'd1);
    check_eq("gnt_latency", n, exp_lat);
    check_eq("gnt_vec", 32'(gnt), 32'(1) << k);
    check_eq("tx_data", 32'(tx_data), 32'(data[k*DW +: DW]));
    check_eq("owner", 32'(owner), k);
    check_eq("start_on_grant", {30'd0, tx_start, busy}, 32'd3);
    last_owner = k;
    exp_data   = data[k*DW +: DW];
  endtask

  // Carries the granted frame through the transmitter handshake; garbles req_i while
  // busy and leaves nmask/ndata presented for the next arbitration.
  task automatic frame(input int unsigned d, input int unsigned len,
                       input logic [N-1:0] nmask, input logic [N*DW-1:0] ndata);
    bit          ok = 1'b1;
    int unsigned e  = 0;
    for (int unsigned i = 0; i < d; i++) begin
      tick();
      if (!tx_start || gnt != '0 || done != '0) ok = 1'b0;
    end
    check_eq("launch_hold", 32'(ok), 32'd1);
    tx_active = 1'b1;
    ok = 1'b1;
    while (e < len) begin
      tick();
      e++;
      if (e == 1) begin
        check_eq("start_drop", 32'(tx_start), 32'd0);
        req  = '0;
        data = ndata;
      end else begin
        req = N'($urandom);
      end
      if (gnt != '0 || done != '0 || tx_data !== exp_data || !busy) ok = 1'b0;
    end
    tx_active = 1'b0;
    req       = nmask;
    while (done == '0 && e < len + 50) begin
      tick();
      e++;
      if (gnt != '0 || tx_data !== exp_data) ok = 1'b0;
    end
    check_eq("busy_quiet", 32'(ok), 32'd1);
    check_eq("done_latency", e, (len + 1 > 3) ? len + 1 : 3);
    check_eq("done_vec", 32'(done), 32'(1) << last_owner);
    check_eq("done_gnt_excl", 32'(gnt), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    req       = '0;
    data      = '0;
    tx_active = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_start", 32'(tx_start), 32'd0);
    check_eq("rst_data", 32'(tx_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_owner", 32'(owner), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    last_owner = N - 1;
    exp_data   = '0;

    data = 32'h0000_0055;
    req  = 4'b0001;
    expect_grant(1);
    frame(2, 3, 4'b0100, $urandom);
    expect_grant(GAP + 1);
    frame(1, 2, 4'b0101, $urandom);
    expect_grant(GAP + 1);
    frame(0, 4, 4'b0101, $urandom);
    expect_grant(GAP + 1);

    for (int unsigned r = 0; r < 20; r++) begin
      frame($urandom_range(0, 4), $urandom_range(2, 6), N'($urandom_range(1, (1 << N) - 1)), $urandom);
      expect_grant(GAP + 1);
    end

    tx_active = 1'b1;
    repeat (3) tick();
    reset     = 1'b1;
    tx_active = 1'b0;
    req       = '0;
    data      = 32'hA3A2_A1A0;
    req       = 4'b1111;
    tick();
    reset = 1'b0;
    check_eq("midrst_start", 32'(tx_start), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    check_eq("midrst_owner", 32'(owner), 32'd0);
    last_owner = N - 1;
    exp_data   = '0;
    expect_grant(1);
    for (int unsigned r = 0; r < 4; r++) begin
      frame(1, 2, 4'b1111, 32'hA3A2_A1A0);
      expect_grant(GAP + 1);
    end

`ifdef UART_ARB_TIMEOUT_EN
    begin
      int unsigned n  = 0;
      bit          ok = 1'b1;
      req = '0;
      do begin
        tick();
        n++;
        if (err == 1'b0 && (!tx_start || done != '0)) ok = 1'b0;
      end while (err == 1'b0 && n < 300);
      check_eq("wd_hold", 32'(ok), 32'd1);
      check_eq("wd_latency", n, TMO);
      check_eq("wd_after", {29'd0, tx_start, busy, done != '0}, 32'd2);
      req = 4'b0011;
      expect_grant(GAP + 1);
    end
`endif

    frame(2, 3, '0, $urandom);
    begin
      bit ok = 1'b1;
      repeat (GAP + 2) begin
        tick();
        if (gnt != '0 || done != '0 || err) ok = 1'b0;
      end
      check_eq("final_quiet", 32'(ok), 32'd1);
      check_eq("final_busy", 32'(busy), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
